mul12u_share_arb: RTL and testbench
===================================

Name: mul12u_share_arb

Overview:
- Shares one pipelined 12x12 unsigned exact multiplier between NREQ requesters; the product is full-width, 24 bits.
- Each requester presents operands with a valid/ready handshake.
- The arbiter grants at most one requester per cycle and issues its operands into the multiplier pipeline.
- Each result returns with the requester's ID after a fixed latency.
- Sits in front of the multiplier in accelerator datapaths where LUT budget forbids one multiplier per lane.

Parameters:
- NREQ, 4, number of requesters (2..16).
- LATENCY, 2, register stages from issue to result (1..4); stage 1 registers operands, later stages register the product.
- IDW, $clog2(NREQ), width of the requester ID.
- CNTW, 16, width of the issued-operation counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  NREQ*12  operand A; requester i occupies bits [12i+11:12i].
- req_b  in  NREQ*12  operand B, same packing as req_a.
- resp_valid  out  1  result valid, single-cycle pulse per operation.
- resp_id  out  IDW  index of the requester that issued the result.
- resp_z  out  24  product A*B, exact and unsigned.
- busy  out  1  high while any operation is in the pipeline.
- ops_cnt  out  CNTW  count of accepted operations; wraps modulo 2^CNTW.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - resp_valid=0, resp_id=0, resp_z=0, busy=0, ops_cnt=0.
  - Priority pointer = 0.
  - All pipeline valid bits cleared.
  - Reset mid-operation discards in-flight operations; no response is emitted for them.
- Arbitration (combinational):
  - req_ready = one-hot of the winning requester among the bits of req_valid, or all-zero if req_valid==0.
  - req_ready[i] never asserts without req_valid[i].
  - No response backpressure exists, so a grant is given every cycle any request is valid. Throughput is 1 operation per cycle.
- Accept: requester i is accepted when req_valid[i] & req_ready[i] at a rising edge.
  - Its a, b and ID are captured into stage 1 with valid=1.
  - ops_cnt increments by 1, wrapping from 2^CNTW-1 to 0.
- Pipeline:
  - Valid, ID and data shift one stage per cycle unconditionally.
  - The product is computed from the stage-1 operands.
  - Operation accepted at edge t produces resp_valid=1 with its resp_id and resp_z during the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - resp_id/resp_z hold their last value when resp_valid=0.
- busy = OR of all pipeline valid bits; it does not include the current-cycle request.
- Results return in issue order; no reordering.
- Simultaneous requests: exactly one wins; the others keep req_valid high and must hold a/b stable until granted.
- A requester may drop req_valid without being granted; it is then simply not served.
- Arithmetic:
  - Exact unsigned product; 4095*4095 = 16769025 = 0xFFE001.
  - Zero operands are legal: 0*x = 0.

Optional Feature:
- Macro: MUL12_ARB_RR_EN.
- Defined (round-robin):
  - The search starts at the priority pointer and wraps modulo NREQ.
  - After each accept the pointer becomes (winner+1) mod NREQ.
  - The pointer is unchanged on cycles with no accept.
  - Guarantees every continuously-requesting requester is granted within NREQ cycles.
- Undefined (fixed priority):
  - The lowest index wins.
  - The pointer register is not implemented.
  - Starvation of high indices is permitted.

Test Plan:
- Single request: after reset, req_valid=4'b0010, a=3, b=5 for one cycle -> req_ready=4'b0010 that cycle; LATENCY=2 cycles later resp_valid=1, resp_id=1, resp_z=15; busy high for 2 cycles; ops_cnt=1.
- Corner values: requester 0 issues 4095*4095, then 0*4095, back-to-back -> consecutive results 0xFFE001 then 0, both id=0.
- Contention with MUL12_ARB_RR_EN: all four valid continuously, with operands a=i+1, b=10 -> grants cycle 0,1,2,3 = ids 0,1,2,3, repeating; results 10, 20, 30, 40 in that order, one per cycle.
- Contention without the macro: same stimulus -> requester 0 granted every cycle, others' req_ready stays 0, results all 10.
- Reset mid-flight: accept 7*9, assert rst the next cycle before the result emerges -> resp_valid never pulses; busy=0 and ops_cnt=0 immediately on assertion; after release, a new 2*2 returns 4 with correct latency.
- Counter wrap: with CNTW=4, accept 17 operations -> ops_cnt reads 1; every result is correct and in order.

Source files
------------

// File: rtl/mul12u_share_arb.sv
// One pipelined 12x12 unsigned multiplier shared by NREQ requesters, with results tagged by requester ID.
// The MUL12_ARB_RR_EN macro selects round-robin arbitration; when it is not defined, the lowest index wins.
module mul12u_share_arb #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2,
    parameter int IDW     = $clog2(NREQ),
    parameter int CNTW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*12-1:0] req_a,
    input  logic [NREQ*12-1:0] req_b,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [23:0]       resp_z,
    output logic              busy,
    output logic [CNTW-1:0]   ops_cnt
);

    // Handshake: requester i transfers on a rising edge where req_valid[i] && req_ready[i].
    // req_ready is a combinational one-hot grant that never asserts without the matching valid.
    // There is no response backpressure, so some request is granted on every cycle that has a valid request.

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  idx;
    logic [IDW:0]    sum;
    logic            accept;
    logic [11:0]     sel_a;
    logic [11:0]     sel_b;

`ifdef MUL12_ARB_RR_EN
    logic [IDW-1:0]  ptr;
`endif

    // The search visits requesters from lowest to highest priority, so the last valid requester it finds wins.
    always_comb begin
        grant  = '0;
        win_id = '0;
        idx    = '0;
        sum    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef MUL12_ARB_RR_EN
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
`else
            idx = IDW'(k);
`endif
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                win_id     = idx;
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_a = req_a[12*k +: 12];
                sel_b = req_b[12*k +: 12];
            end
        end
    end

`ifdef MUL12_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (accept)
            ptr <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
    end
`endif

    // Valid bits shift every cycle. Data registers load only behind a valid bit, so they hold their values between operations.
    logic [LATENCY:1]          v_q;
    logic [LATENCY:1][IDW-1:0] id_q;
    logic [11:0]               a_q;
    logic [11:0]               b_q;
    logic [23:0]               prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ops_cnt <= '0;
        end else begin
            v_q[1] <= accept;
            if (accept) begin
                a_q     <= sel_a;
                b_q     <= sel_b;
                id_q[1] <= win_id;
                ops_cnt <= ops_cnt + CNTW'(1);
            end
            for (int k = 2; k <= LATENCY; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1])
                    id_q[k] <= id_q[k-1];
            end
        end
    end

    assign prod = {12'd0, a_q} * {12'd0, b_q};

    generate
        if (LATENCY == 1) begin : g_lat1
            assign resp_z = prod;
        end else begin : g_latn
            // zp[0] holds the product in stage 2; zp[LATENCY-2] is the output stage.
            logic [LATENCY-2:0][23:0] zp;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    zp <= '0;
                end else begin
                    if (v_q[1])
                        zp[0] <= prod;
                    for (int k = 1; k <= LATENCY - 2; k++) begin
                        if (v_q[k+1])
                            zp[k] <= zp[k-1];
                    end
                end
            end
            assign resp_z = zp[LATENCY-2];
        end
    endgenerate

    assign resp_valid = v_q[LATENCY];
    assign resp_id    = id_q[LATENCY];
    assign busy       = |v_q;

endmodule

// File: tb/tb_mul12u_share_arb.sv
// Directed, table-driven bench for mul12u_share_arb, with a response scoreboard checked in issue order.
module tb_mul12u_share_arb;
    localparam int NREQ    = 4;
    localparam int LATENCY = 2;
    localparam int IDW     = 2;
    localparam int CNTW    = 4;
    localparam int W       = IDW + 24;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*12-1:0]  req_a = '0;
    logic [NREQ*12-1:0]  req_b = '0;
    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [23:0]         resp_z;
    logic                busy;
    logic [CNTW-1:0]     ops_cnt;

    mul12u_share_arb #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_z(resp_z),
        .busy(busy), .ops_cnt(ops_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response must match the oldest expected entry.
    always @(negedge clk) begin
        logic [W-1:0] item;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got id=%0d z=0x%0h, required no response", resp_id, resp_z);
            end else begin
                item = exp_q.pop_front();
                check("sb_resp_id", 32'(resp_id), 32'(item[W-1:24]));
                check("sb_resp_z", 32'(resp_z), 32'(item[23:0]));
            end
        end
    end

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ*12-1:0] a;
        logic [NREQ*12-1:0] b;
        logic [NREQ-1:0]    exp_ready;
        logic               exp_resp;
        logic [IDW-1:0]     exp_id;
        logic [23:0]        exp_z;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_win;
        int slot;
        // Operands are listed {req3, req2, req1, req0}.
        vecs[0] = '{4'b0010, {12'd0, 12'd0, 12'd3, 12'd0},     {12'd0, 12'd0, 12'd5, 12'd0},     4'b0010, 1'b1, 2'd1, 24'd15};
        vecs[1] = '{4'b0001, {12'd0, 12'd0, 12'd0, 12'd4095},  {12'd0, 12'd0, 12'd0, 12'd4095},  4'b0001, 1'b1, 2'd0, 24'hFFE001};
        vecs[2] = '{4'b1000, {12'd0, 12'd0, 12'd0, 12'd0},     {12'd4095, 12'd0, 12'd0, 12'd0},  4'b1000, 1'b1, 2'd3, 24'd0};
        vecs[3] = '{4'b1100, {12'd7, 12'd100, 12'd0, 12'd0},   {12'd9, 12'd200, 12'd0, 12'd0},   4'b0100, 1'b1, 2'd2, 24'd20000};
        vecs[4] = '{4'b1010, {12'd5, 12'd0, 12'd12, 12'd0},    {12'd5, 12'd0, 12'd34, 12'd0},    4'b0010, 1'b1, 2'd1, 24'd408};
        vecs[5] = '{4'b1000, {12'd2048, 12'd0, 12'd0, 12'd0},  {12'd2, 12'd0, 12'd0, 12'd0},     4'b1000, 1'b1, 2'd3, 24'd4096};
        vecs[6] = '{4'b0110, {12'd0, 12'd9, 12'd4095, 12'd0},  {12'd0, 12'd9, 12'd1, 12'd0},     4'b0010, 1'b1, 2'd1, 24'd4095};
        vecs[7] = '{4'b0000, {12'd1, 12'd1, 12'd1, 12'd1},     {12'd1, 12'd1, 12'd1, 12'd1},     4'b0000, 1'b0, 2'd0, 24'd0};
        vecs[8] = '{4'b1111, {12'd1, 12'd2, 12'd3, 12'd4000},  {12'd1, 12'd2, 12'd3, 12'd4001},  4'b0001, 1'b1, 2'd0, 24'd16004000};

        // Single-operation vectors. Each starts from reset, so the round-robin pointer is 0 and both arbiters pick the lowest index.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_id", 32'(resp_id), 32'd0);
            check("rst_resp_z", 32'(resp_z), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ops_cnt", 32'(ops_cnt), 32'd0);
            req_valid = vecs[i].valid;
            req_a = vecs[i].a;
            req_b = vecs[i].b;
            #1;
            check("vec_ready", 32'(req_ready), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_resp)
                exp_q.push_back({vecs[i].exp_id, vecs[i].exp_z});
            @(negedge clk);
            req_valid = '0;
            check("vec_ops_cnt", 32'(ops_cnt), 32'(vecs[i].exp_resp));
            check("vec_busy", 32'(busy), 32'(vecs[i].exp_resp));
            for (int c = 1; c <= LATENCY; c++) begin
                if (c > 1) @(negedge clk);
                check("vec_resp_valid", 32'(resp_valid), 32'(vecs[i].exp_resp && c == LATENCY));
            end
            @(negedge clk);
            check("vec_idle_valid", 32'(resp_valid), 32'd0);
            check("vec_idle_busy", 32'(busy), 32'd0);
            if (vecs[i].exp_resp)
                check("vec_hold_z", 32'(resp_z), 32'(vecs[i].exp_z));
            drain();
        end

        // Requester 0 issues two back-to-back operations using the extreme operand values.
        do_reset();
        req_valid = 4'b0001;
        req_a = '0; req_b = '0;
        req_a[11:0] = 12'd4095; req_b[11:0] = 12'd4095;
        #1 check("b2b_ready0", 32'(req_ready), 32'h1);
        exp_q.push_back({2'd0, 24'hFFE001});
        @(negedge clk);
        req_a[11:0] = 12'd0;
        #1 check("b2b_ready1", 32'(req_ready), 32'h1);
        exp_q.push_back({2'd0, 24'd0});
        @(negedge clk);
        req_valid = '0;
        repeat (LATENCY - 2) @(negedge clk);
        check("b2b_first_valid", 32'(resp_valid), 32'd1);
        check("b2b_first_z", 32'(resp_z), 32'hFFE001);
        @(negedge clk);
        check("b2b_second_valid", 32'(resp_valid), 32'd1);
        check("b2b_second_z", 32'(resp_z), 32'd0);
        @(negedge clk);
        check("b2b_end_valid", 32'(resp_valid), 32'd0);
        drain();

        // All four requesters stay valid for 8 cycles with a = i+1 and b = 10.
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_a[12*i +: 12] = 12'(i + 1);
            req_b[12*i +: 12] = 12'd10;
        end
        for (int c = 0; c < 8; c++) begin
            #1;
`ifdef MUL12_ARB_RR_EN
            exp_win = c % NREQ;
`else
            exp_win = 0;
`endif
            check("cont_ready", 32'(req_ready), 32'(1) << exp_win);
            exp_q.push_back({IDW'(exp_win), 24'((exp_win + 1) * 10)});
            @(negedge clk);
        end
        req_valid = '0;
        check("cont_ops_cnt", 32'(ops_cnt), 32'd8);
        drain();

        // Reset while an operation is in flight, then check a clean operation afterwards.
        do_reset();
        req_valid = 4'b0001;
        req_a[11:0] = 12'd7; req_b[11:0] = 12'd9;
        @(negedge clk);
        req_valid = '0;
        check("mid_busy_before", 32'(busy), 32'd1);
        check("mid_cnt_before", 32'(ops_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_busy_rst", 32'(busy), 32'd0);
        check("mid_cnt_rst", 32'(ops_cnt), 32'd0);
        check("mid_valid_rst", 32'(resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 4'b0001;
        req_a[11:0] = 12'd2; req_b[11:0] = 12'd2;
        #1 check("mid_new_ready", 32'(req_ready), 32'h1);
        exp_q.push_back({2'd0, 24'd4});
        @(negedge clk);
        req_valid = '0;
        repeat (LATENCY - 1) @(negedge clk);
        check("mid_new_valid", 32'(resp_valid), 32'd1);
        check("mid_new_z", 32'(resp_z), 32'd4);
        drain();

        // 17 operations wrap the 4-bit counter around to 1.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            slot = k % NREQ;
            req_valid = '0;
            req_valid[slot] = 1'b1;
            req_a = '0; req_b = '0;
            req_a[12*slot +: 12] = 12'(k + 1);
            req_b[12*slot +: 12] = 12'(k + 2);
            exp_q.push_back({IDW'(slot), 24'((k + 1) * (k + 2))});
            @(negedge clk);
        end
        req_valid = '0;
        check("wrap_ops_cnt", 32'(ops_cnt), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
